// File: rtl/bus_arbiter_rr_bcast.sv
// Single-bus arbiter/router between per-driver source FIFOs and destination FIFOs.
// One source wins arbitration (round-robin or fixed priority). Its head packet is
// popped, and the packet is then pushed to the destination named in its top id_w
// bits, or to every other port on broadcast. Bad IDs are dropped and counted.
module bus_arbiter_rr_bcast #(
    parameter int                drvrs     = 4,
    parameter int                pckg_sz   = 16,
    parameter int                id_w      = 8,
    parameter logic [id_w-1:0]   broadcast = {id_w{1'b1}},
    parameter bit                arb_mode  = 1'b0,
    parameter int                cnt_w     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [drvrs-1:0]             pndng,
    input  logic [drvrs*pckg_sz-1:0]     D_pop,
    output logic [drvrs-1:0]             pop,
    input  logic [drvrs-1:0]             full,
    output logic [drvrs-1:0]             push,
    output logic [pckg_sz-1:0]           D_push,
    output logic                         busy,
    output logic [$clog2(drvrs)-1:0]     gnt_id,
    output logic [cnt_w-1:0]             drop_cnt
);

    localparam int gw = $clog2(drvrs);

    typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;

    state_t              state;
    logic [pckg_sz-1:0]  pkt_r;
    logic [gw-1:0]       rr_start;
    logic [gw-1:0]       rr_next;
    logic [gw-1:0]       winner;
    logic                found;
    int                  idx;
    logic [id_w-1:0]     dest;
    logic                dest_is_bcast;
    logic                dest_is_uni;
    logic [drvrs-1:0]    uni_mask;
    logic [drvrs-1:0]    bcast_mask;
    logic                uni_ready;
    logic                bcast_ready;

    // The latched packet doubles as the output data bus; it is only meaningful with push.
    assign D_push = pkt_r;

    // Pick the first pending source, scanning circularly from the round-robin start (or 0).
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < drvrs; k++) begin
            idx = (arb_mode ? 0 : int'(rr_start)) + k;
            if (idx >= drvrs) begin
                idx = idx - drvrs;
            end
            if (!found && pndng[idx]) begin
                found  = 1'b1;
                winner = gw'(idx);
            end
        end
    end

    // Decode the latched packet's destination into unicast / broadcast target masks.
    always_comb begin
        dest          = pkt_r[pckg_sz-1 -: id_w];
        dest_is_bcast = (dest == broadcast);
        dest_is_uni   = !dest_is_bcast && (int'(dest) < drvrs) && (int'(dest) != int'(gnt_id));
        uni_mask      = '0;
        bcast_mask    = '0;
        for (int i = 0; i < drvrs; i++) begin
            uni_mask[i]   = dest_is_uni && (int'(dest) == i);
            bcast_mask[i] = (i != int'(gnt_id));
        end
        uni_ready   = ((full & uni_mask) == '0);
        bcast_ready = ((full & bcast_mask) == '0);
        if (int'(gnt_id) == drvrs - 1) begin
            rr_next = '0;
        end else begin
            rr_next = gnt_id + gw'(1);
        end
    end

    // Arbitration FSM: grant, pop one packet, then deliver or drop it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pop      <= '0;
            push     <= '0;
            pkt_r    <= '0;
            busy     <= 1'b0;
            gnt_id   <= '0;
            drop_cnt <= '0;
            rr_start <= '0;
        end else begin
            pop  <= '0;
            push <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_id <= winner;
                        busy   <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (pndng[gnt_id]) begin
                        pop[gnt_id] <= 1'b1;
                        pkt_r       <= D_pop[gnt_id*pckg_sz +: pckg_sz];
                        state       <= DELIVER;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DELIVER: begin
                    if (dest_is_bcast) begin
                        if (bcast_ready) begin
                            push     <= bcast_mask;
                            busy     <= 1'b0;
                            rr_start <= rr_next;
                            state    <= IDLE;
                        end
                    end else if (dest_is_uni) begin
                        if (uni_ready) begin
                            push     <= uni_mask;
                            busy     <= 1'b0;
                            rr_start <= rr_next;
                            state    <= IDLE;
                        end
                    end else begin
                        if (drop_cnt != {cnt_w{1'b1}}) begin
                            drop_cnt <= drop_cnt + cnt_w'(1);
                        end
                        busy     <= 1'b0;
                        rr_start <= rr_next;
                        state    <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr_bcast.sv
// Directed bench for bus_arbiter_rr_bcast: a round-robin instance, a fixed-priority
// instance and a narrow-counter instance all see the same stimulus.
module tb_bus_arbiter_rr_bcast;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] D_pop;
    logic [N-1:0]   full;

    logic [N-1:0]   pop0, push0, pop1, push1, pop2, push2;
    logic [W-1:0]   dpush0, dpush1, dpush2;
    logic           busy0, busy1, busy2;
    logic [1:0]     gnt0, gnt1, gnt2;
    logic [15:0]    drop0, drop1;
    logic [1:0]     drop2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          src;
        logic [15:0] pkt;
        logic [3:0]  fl;
        logic [3:0]  exp_push;
        int          exp_drop;
    } vec_t;

    vec_t vecs[10];

    // Free-running clock
    always #5 clk = ~clk;

    bus_arbiter_rr_bcast #(.arb_mode(1'b0)) dut_rr (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop0),
        .full(full), .push(push0), .D_push(dpush0), .busy(busy0),
        .gnt_id(gnt0), .drop_cnt(drop0)
    );

    bus_arbiter_rr_bcast #(.arb_mode(1'b1)) dut_fp (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop1),
        .full(full), .push(push1), .D_push(dpush1), .busy(busy1),
        .gnt_id(gnt1), .drop_cnt(drop1)
    );

    bus_arbiter_rr_bcast #(.cnt_w(2)) dut_c2 (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop2),
        .full(full), .push(push2), .D_push(dpush2), .busy(busy2),
        .gnt_id(gnt2), .drop_cnt(drop2)
    );

    task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task applyStimulus(input int src, input logic [15:0] pkt, input logic [3:0] fl);
        pndng           = '0;
        pndng[src]      = 1'b1;
        D_pop           = '0;
        D_pop[src*W +: W] = pkt;
        full            = fl;
    endtask

    initial begin
        vecs[0] = '{1, 16'h02A5, 4'b0001, 4'b0100, 0};
        vecs[1] = '{0, 16'h0734, 4'b0000, 4'b0000, 1};
        vecs[2] = '{1, 16'h0199, 4'b0000, 4'b0000, 2};
        vecs[3] = '{3, 16'h0012, 4'b1000, 4'b0001, 2};
        vecs[4] = '{2, 16'hFF3C, 4'b0100, 4'b1011, 2};
        vecs[5] = '{0, 16'hFF00, 4'b0000, 4'b1110, 2};
        vecs[6] = '{3, 16'h0355, 4'b0000, 4'b0000, 3};
        vecs[7] = '{2, 16'h0400, 4'b0000, 4'b0000, 4};
        vecs[8] = '{0, 16'h0377, 4'b0000, 4'b1000, 4};
        vecs[9] = '{1, 16'hFE01, 4'b0000, 4'b0000, 5};

        // Reset held with every source pending
        reset = 1'b1;
        pndng = 4'b1111;
        full  = '0;
        D_pop = '0;
        D_pop[0*W +: W] = 16'h0100;
        D_pop[1*W +: W] = 16'h00A1;
        D_pop[2*W +: W] = 16'h00A2;
        D_pop[3*W +: W] = 16'h00A3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset_pop", pop0, 0);
            checkOutput("reset_push", push0, 0);
            checkOutput("reset_busy", busy0, 0);
            checkOutput("reset_drop", drop0, 0);
        end
        reset = 1'b0;
        tick();
        checkOutput("first_gnt_rr", gnt0, 0);
        checkOutput("first_gnt_fp", gnt1, 0);
        checkOutput("first_busy", busy0, 1);

        // Fairness: rr rotates 0,1,2,3,... while fixed priority keeps picking 0
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("rr_pop", pop0, 32'(1) << (k % 4));
            checkOutput("fp_pop", pop1, 32'h1);
            tick();
            checkOutput("rr_push", push0, (k % 4 == 0) ? 32'h2 : 32'h1);
            checkOutput("fp_push", push1, 32'h2);
            tick();
        end

        reset = 1'b1;
        pndng = '0;
        tick();
        reset = 1'b0;
        tick();

        // Table of single-source transactions
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].src, vecs[v].pkt, vecs[v].fl);
            tick();
            checkOutput("vec_gnt", gnt0, vecs[v].src);
            checkOutput("vec_busy", busy0, 1);
            tick();
            checkOutput("vec_pop", pop0, 32'(1) << vecs[v].src);
            pndng = '0;
            tick();
            checkOutput("vec_push", push0, vecs[v].exp_push);
            if (vecs[v].exp_push != 4'b0000) begin
                checkOutput("vec_dpush", dpush0, vecs[v].pkt);
            end
            checkOutput("vec_drop", drop0, vecs[v].exp_drop);
            checkOutput("vec_drop_sat", drop2, (vecs[v].exp_drop > 3) ? 3 : vecs[v].exp_drop);
            tick();
            checkOutput("vec_idle_busy", busy0, 0);
            checkOutput("vec_idle_push", push0, 0);
        end

        // Source withdraws its request before the pop
        applyStimulus(0, 16'h0100, 4'b0000);
        tick();
        checkOutput("abort_gnt_busy", busy0, 1);
        pndng = '0;
        tick();
        checkOutput("abort_pop", pop0, 0);
        checkOutput("abort_busy", busy0, 0);
        tick();
        checkOutput("abort_push", push0, 0);

        // Broadcast stalled by full[3]; the source's own full never blocks
        applyStimulus(2, 16'hFF3C, 4'b1100);
        tick();
        tick();
        checkOutput("bc_pop", pop0, 32'h4);
        pndng = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bc_stall_push", push0, 0);
            checkOutput("bc_stall_busy", busy0, 1);
        end
        full = 4'b0100;
        tick();
        checkOutput("bc_push", push0, 32'hB);
        checkOutput("bc_dpush", dpush0, 32'hFF3C);
        tick();
        checkOutput("bc_push_once", push0, 0);
        checkOutput("bc_busy_end", busy0, 0);

        // Reset while a unicast is stalled in delivery
        applyStimulus(3, 16'h0166, 4'b0010);
        tick();
        tick();
        checkOutput("rst_mid_pop", pop0, 32'h8);
        pndng = '0;
        tick();
        checkOutput("rst_mid_stall", push0, 0);
        tick();
        checkOutput("rst_mid_stall", push0, 0);
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_busy", busy0, 0);
        checkOutput("rst_mid_push", push0, 0);
        reset = 1'b0;
        full  = '0;
        tick();
        checkOutput("rst_after_push", push0, 0);
        tick();
        checkOutput("rst_after_busy", busy0, 0);
        pndng = 4'b1010;
        D_pop = '0;
        tick();
        checkOutput("rst_after_gnt", gnt0, 1);
        tick();
        checkOutput("rst_after_pop", pop0, 32'h2);
        pndng = '0;
        tick();
        checkOutput("rst_after_deliver", push0, 32'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
